// File: rtl/ds_block_mask_accum_if.sv
// ds_block_mask_accum_if: block-raster mask samples in, downsampled block results out.
// DS_MASK_STATS_EN adds active_blocks_out.
interface ds_block_mask_accum_if #(
    parameter int AW = 12,
    parameter int CW = 5
);
    logic [10:0]   hcount_ds_in;
    logic [9:0]    vcount_ds_in;
    logic          valid_ds_in;
    logic          mask_in;
    logic [AW-1:0] ds_addr_out;
    logic [CW-1:0] ds_count_out;
    logic          ds_bit_out;
    logic          ds_valid_out;
    logic          frame_done_out;
`ifdef DS_MASK_STATS_EN
    logic [AW:0]   active_blocks_out;
    modport master (
        output hcount_ds_in, vcount_ds_in, valid_ds_in, mask_in,
        input  ds_addr_out, ds_count_out, ds_bit_out, ds_valid_out, frame_done_out, active_blocks_out
    );
    modport slave (
        input  hcount_ds_in, vcount_ds_in, valid_ds_in, mask_in,
        output ds_addr_out, ds_count_out, ds_bit_out, ds_valid_out, frame_done_out, active_blocks_out
    );
`else
    modport master (
        output hcount_ds_in, vcount_ds_in, valid_ds_in, mask_in,
        input  ds_addr_out, ds_count_out, ds_bit_out, ds_valid_out, frame_done_out
    );
    modport slave (
        input  hcount_ds_in, vcount_ds_in, valid_ds_in, mask_in,
        output ds_addr_out, ds_count_out, ds_bit_out, ds_valid_out, frame_done_out
    );
`endif
endinterface

// File: rtl/ds_block_mask_accum.sv
// ds_block_mask_accum: reduces each FILTER_SIZE^2 mask block to a set-pixel count and thresholded bit.
// DS_MASK_STATS_EN adds a per-frame count of set downsampled bits on active_blocks_out.
module ds_block_mask_accum #(
    parameter int CAM_WIDTH   = 240,
    parameter int CAM_HEIGHT  = 320,
    parameter int FILTER_SIZE = 5,
    parameter int THRESHOLD   = 13
) (
    input logic clk_in,
    input logic rst_in,
    ds_block_mask_accum_if.slave bus
);
    localparam int BW = CAM_WIDTH / FILTER_SIZE;
    localparam int BH = CAM_HEIGHT / FILTER_SIZE;
    localparam int NB = BW * BH;
    localparam int AW = $clog2(NB);
    localparam int CW = $clog2(FILTER_SIZE * FILTER_SIZE + 1);
    localparam int PW = $clog2(FILTER_SIZE);

    if (CAM_WIDTH % FILTER_SIZE != 0 || CAM_HEIGHT % FILTER_SIZE != 0 ||
        THRESHOLD < 1 || THRESHOLD > FILTER_SIZE * FILTER_SIZE) begin : g_bad_cfg
        $error("ds_block_mask_accum: invalid frame size / filter size / threshold");
    end

    typedef enum logic {IDLE, SCAN} state_t;
    state_t r_state, w_state_nx;

    logic [PW-1:0] r_vph, r_hph;
    logic [CW-1:0] r_acc, r_count_out;
    logic [AW-1:0] r_addr, r_addr_out;
    logic          r_bit_out, r_valid_out, r_done_out;
    logic          w_start, w_adv, w_blk_done, w_last_blk, w_bit;
    logic [CW-1:0] w_sum;

    assign w_start    = bus.valid_ds_in && bus.hcount_ds_in == '0 && bus.vcount_ds_in == '0;
    assign w_adv      = !w_start && r_state == SCAN && bus.valid_ds_in;
    assign w_blk_done = r_vph == PW'(FILTER_SIZE - 1) && r_hph == PW'(FILTER_SIZE - 1);
    assign w_last_blk = r_addr == AW'(NB - 1);
    assign w_sum      = r_acc + CW'(bus.mask_in);
    assign w_bit      = w_sum >= CW'(THRESHOLD);

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_nx;

    always_comb
        w_state_nx = w_start ? SCAN : (w_adv && w_blk_done && w_last_blk) ? IDLE : r_state;

    // (0,0) is always pixel 0 of block 0, so it (re)loads rather than accumulates
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vph       <= '0;
            r_hph       <= '0;
            r_acc       <= '0;
            r_addr      <= '0;
            r_addr_out  <= '0;
            r_count_out <= '0;
            r_bit_out   <= 1'b0;
            r_valid_out <= 1'b0;
            r_done_out  <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            r_done_out  <= 1'b0;
            if (w_start) begin
                r_vph  <= PW'(1);
                r_hph  <= '0;
                r_acc  <= CW'(bus.mask_in);
                r_addr <= '0;
            end else if (w_adv) begin
                if (w_blk_done) begin
                    r_vph       <= '0;
                    r_hph       <= '0;
                    r_acc       <= '0;
                    r_addr      <= w_last_blk ? '0 : r_addr + 1'b1;
                    r_addr_out  <= r_addr;
                    r_count_out <= w_sum;
                    r_bit_out   <= w_bit;
                    r_valid_out <= 1'b1;
                    r_done_out  <= w_last_blk;
                end else begin
                    r_acc <= w_sum;
                    r_vph <= (r_vph == PW'(FILTER_SIZE - 1)) ? '0 : r_vph + 1'b1;
                    r_hph <= (r_vph == PW'(FILTER_SIZE - 1)) ? r_hph + 1'b1 : r_hph;
                end
            end
        end
    end

    assign bus.ds_addr_out    = r_addr_out;
    assign bus.ds_count_out   = r_count_out;
    assign bus.ds_bit_out     = r_bit_out;
    assign bus.ds_valid_out   = r_valid_out;
    assign bus.frame_done_out = r_done_out;

`ifdef DS_MASK_STATS_EN
    logic [AW:0] r_bits, r_active_out;
    // running tally is cleared at every (re)start so abandoned frames never publish
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_bits       <= '0;
            r_active_out <= '0;
        end else if (w_start) begin
            r_bits <= '0;
        end else if (w_adv && w_blk_done) begin
            r_bits <= r_bits + (AW+1)'(w_bit);
            if (w_last_blk) r_active_out <= r_bits + (AW+1)'(w_bit);
        end
    end
    assign bus.active_blocks_out = r_active_out;
`endif
endmodule

// File: tb/tb_ds_block_mask_accum.sv
// tb_ds_block_mask_accum: directed frames against a sample-count reference model plus literal checks.
module tb_ds_block_mask_accum;
    localparam int NPIX = 240 * 320;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_on = 1'b0;

    ds_block_mask_accum_if #(.AW(12), .CW(5)) bus ();

    ds_block_mask_accum dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    always #5 clk = ~clk;

    // reference: blocks are just consecutive groups of 25 samples counted from the last (0,0)
    bit          m_active = 1'b0;
    int          m_n = 0, m_sum = 0, m_bits = 0;
    logic        m_valid = 1'b0, m_done = 1'b0, m_bit = 1'b0;
    logic [11:0] m_addr = '0;
    logic [4:0]  m_count = '0;
    logic [12:0] m_active_blocks = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_n = 0; m_sum = 0; m_bits = 0;
            m_valid = 1'b0; m_done = 1'b0; m_bit = 1'b0; m_addr = '0; m_count = '0;
            m_active_blocks = '0;
        end else begin
            m_valid = 1'b0;
            m_done  = 1'b0;
            if (bus.valid_ds_in && bus.hcount_ds_in == 0 && bus.vcount_ds_in == 0) begin
                m_active = 1'b1; m_n = 1; m_sum = int'(bus.mask_in); m_bits = 0;
            end else if (bus.valid_ds_in && m_active) begin
                m_n++;
                m_sum += int'(bus.mask_in);
                if (m_n % 25 == 0) begin
                    m_valid = 1'b1;
                    m_addr  = 12'(m_n / 25 - 1);
                    m_count = 5'(m_sum);
                    m_bit   = m_sum >= 13;
                    m_bits += int'(m_bit);
                    m_sum   = 0;
                    if (m_n == NPIX) begin
                        m_done = 1'b1;
                        m_active_blocks = 13'(m_bits);
                        m_active = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        vectors++;
        if ({bus.ds_valid_out, bus.frame_done_out, bus.ds_addr_out, bus.ds_count_out, bus.ds_bit_out} !==
            {m_valid, m_done, m_addr, m_count, m_bit}) begin
            miscompares++;
            $display("FAIL cycle t=%0t got v%0b d%0b a%0d c%0d b%0b want v%0b d%0b a%0d c%0d b%0b", $time,
                     bus.ds_valid_out, bus.frame_done_out, bus.ds_addr_out, bus.ds_count_out, bus.ds_bit_out,
                     m_valid, m_done, m_addr, m_count, m_bit);
        end
`ifdef DS_MASK_STATS_EN
        vectors++;
        if (bus.active_blocks_out !== m_active_blocks) begin
            miscompares++;
            $display("FAIL active_blocks t=%0t got %0d want %0d", $time, bus.active_blocks_out, m_active_blocks);
        end
`endif
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    function automatic bit mask_fn(input int kind, input int br, input int bc, input int p);
        case (kind)
            0:       return ((br + bc) % 2) == 0;
            1:       return br == 0 && bc == 0 && p < 13;
            2:       return br == 0 && bc == 0 && p < 12;
            default: return ((br * 7 + bc * 3 + p) % 5) < 2;
        endcase
    endfunction

    task automatic idle(input int n);
        bus.valid_ds_in = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pix(input int h, input int v, input bit m);
        bus.hcount_ds_in = 11'(h);
        bus.vcount_ds_in = 10'(v);
        bus.mask_in      = m;
        bus.valid_ds_in  = 1'b1;
        @(posedge clk); #1;
    endtask

    // emits samples [skip, nsamp) of the block-raster order, with a 7-cycle gap before gap_at
    task automatic run_frame(input int kind, input int nsamp, input int gap_at, input int skip);
        int idx = 0;
        for (int br = 0; br < 64; br++)
            for (int bc = 0; bc < 48; bc++)
                for (int c = 0; c < 5; c++)
                    for (int l = 0; l < 5; l++) begin
                        if (idx >= nsamp) return;
                        if (idx >= skip) begin
                            if (idx == gap_at) idle(7);
                            pix(bc * 5 + c, br * 5 + l, mask_fn(kind, br, bc, c * 5 + l));
                        end
                        idx++;
                    end
        bus.valid_ds_in = 1'b0;
    endtask

    initial begin
        bus.hcount_ds_in = '0; bus.vcount_ds_in = '0; bus.valid_ds_in = 1'b0; bus.mask_in = 1'b0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("reset_valid", int'(bus.ds_valid_out), 0);
        check("reset_addr_count", int'(bus.ds_addr_out) + int'(bus.ds_count_out), 0);
        rst = 1'b0;
        // noise before the frame start must be ignored
        pix(7, 3, 1'b1); pix(8, 3, 1'b1);
        // 13 set pixels in block 0; strobe exactly one clock after the 25th sample
        run_frame(1, 24, -1, 0);
        check("blk0_no_early_strobe", int'(bus.ds_valid_out), 0);
        pix(4, 4, 1'b0);
        check("blk0_13_valid", int'(bus.ds_valid_out), 1);
        check("blk0_13_count", int'(bus.ds_count_out), 13);
        check("blk0_13_bit", int'(bus.ds_bit_out), 1);
        run_frame(2, 25, -1, 0);
        check("blk0_12_count", int'(bus.ds_count_out), 12);
        check("blk0_12_bit", int'(bus.ds_bit_out), 0);
        bus.valid_ds_in = 1'b0;
        // gap mid-block 47, then block 48 wraps to row 1
        run_frame(3, 49 * 25, 47 * 25 + 12, 0);
        check("blk48_valid", int'(bus.ds_valid_out), 1);
        check("blk48_addr", int'(bus.ds_addr_out), 48);
        idle(3);
        check("hold_addr", int'(bus.ds_addr_out), 48);
        // restart with a partial block 24 pending
        run_frame(3, 610, -1, 0);
        idle(2);
        check("partial_held_addr", int'(bus.ds_addr_out), 23);
        run_frame(0, 25, -1, 0);
        check("restart_addr", int'(bus.ds_addr_out), 0);
        check("restart_count", int'(bus.ds_count_out), 25);
        // reset mid-frame, then samples not at (0,0)
        run_frame(3, 30, -1, 0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check("rst_count", int'(bus.ds_count_out), 0);
        run_frame(3, 130, -1, 30);
        idle(2);
        check("post_rst_valid", int'(bus.ds_valid_out), 0);
        check("post_rst_outputs", int'(bus.ds_addr_out) + int'(bus.ds_count_out) + int'(bus.ds_bit_out), 0);
        // full checkerboard frame
        run_frame(0, NPIX, -1, 0);
        check("final_valid", int'(bus.ds_valid_out), 1);
        check("final_done", int'(bus.frame_done_out), 1);
        check("final_addr", int'(bus.ds_addr_out), 3071);
        check("final_count", int'(bus.ds_count_out), 25);
`ifdef DS_MASK_STATS_EN
        check("active_blocks", int'(bus.active_blocks_out), 1536);
`endif
        idle(3);
        check("done_is_strobe", int'(bus.frame_done_out), 0);
        check("idle_after_frame_valid", int'(bus.ds_valid_out), 0);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
